// File: rtl/cache_refill_ctrl.sv
// Cache line refill engine: fetches one line byte-by-byte from backing memory,
// critical byte first, and writes each byte into the line array through a fill port.
module cache_refill_ctrl #(
    parameter  int ADDR_W     = 32,
    parameter  int DATA_W     = 8,
    parameter  int LINE_BYTES = 8,
    localparam int OFF_W      = $clog2(LINE_BYTES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              miss_valid_i,
    output logic              miss_ready_o,
    input  logic [ADDR_W-1:0] miss_addr_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_rsp_valid_i,
    input  logic [DATA_W-1:0] mem_rsp_data_i,
    output logic              fill_we_o,
    output logic [ADDR_W-1:0] fill_addr_o,
    output logic [OFF_W-1:0]  fill_idx_o,
    output logic [DATA_W-1:0] fill_data_o,
    output logic              crit_o,
    output logic              fill_done_o,
    output logic              busy_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; the requester holds valid and its payload stable until then.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] base_q;
    logic [OFF_W-1:0]  cnt_q;
    logic [OFF_W-1:0]  beat_q;
    logic              fill_we_q;
    logic [OFF_W-1:0]  fill_idx_q;
    logic [DATA_W-1:0] fill_data_q;
    logic              crit_q;
    logic              fill_done_q;

    logic miss_accept;
    logic rsp_take;
    logic last_beat;

    assign last_beat = (beat_q == OFF_W'(LINE_BYTES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        miss_accept = 1'b0;
        rsp_take    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (miss_valid_i) begin
                    miss_accept = 1'b1;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid_i) begin
                    rsp_take = 1'b1;
                    state_d  = last_beat ? S_DONE : S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Offset counter is only OFF_W wide, so it wraps inside the line and never
    // carries into the base address.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_q      <= '0;
            cnt_q       <= '0;
            beat_q      <= '0;
            fill_we_q   <= 1'b0;
            fill_idx_q  <= '0;
            fill_data_q <= '0;
            crit_q      <= 1'b0;
            fill_done_q <= 1'b0;
        end else begin
            fill_we_q   <= 1'b0;
            crit_q      <= 1'b0;
            fill_done_q <= 1'b0;
            if (miss_accept) begin
                base_q <= {miss_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                cnt_q  <= miss_addr_i[OFF_W-1:0];
                beat_q <= '0;
            end
            if (rsp_take) begin
                fill_we_q   <= 1'b1;
                fill_idx_q  <= cnt_q;
                fill_data_q <= mem_rsp_data_i;
                crit_q      <= (beat_q == '0);
                fill_done_q <= last_beat;
                cnt_q       <= cnt_q + 1'b1;
                beat_q      <= beat_q + 1'b1;
            end
        end
    end

    assign miss_ready_o    = (state_q == S_IDLE);
    assign busy_o          = (state_q != S_IDLE);
    assign mem_req_valid_o = (state_q == S_REQ);
    assign mem_req_addr_o  = base_q | {{(ADDR_W-OFF_W){1'b0}}, cnt_q};

    assign fill_we_o   = fill_we_q;
    assign fill_addr_o = base_q;
    assign fill_idx_o  = fill_idx_q;
    assign fill_data_o = fill_data_q;
    assign crit_o      = crit_q;
    assign fill_done_o = fill_done_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: byte memory model with programmable backpressure,
// request/fill scoreboards, and directed miss scenarios.
module tb_cache_refill_ctrl;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 8;
    localparam int LINE_BYTES = 8;
    localparam int OFF_W      = 3;
    localparam int FW         = ADDR_W + OFF_W + DATA_W + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic              miss_valid = 1'b0;
    logic              miss_ready;
    logic [ADDR_W-1:0] miss_addr = '0;
    logic              mem_req_valid;
    logic              mem_ready = 1'b1;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              rsp_drv = 1'b0;
    logic [DATA_W-1:0] rsp_data = '0;
    logic              spur = 1'b0;
    logic              fill_we;
    logic [ADDR_W-1:0] fill_addr;
    logic [OFF_W-1:0]  fill_idx;
    logic [DATA_W-1:0] fill_data;
    logic              crit;
    logic              fill_done;
    logic              busy;

    cache_refill_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_BYTES(LINE_BYTES)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .miss_valid_i(miss_valid),
        .miss_ready_o(miss_ready),
        .miss_addr_i(miss_addr),
        .mem_req_valid_o(mem_req_valid),
        .mem_req_ready_i(mem_ready),
        .mem_req_addr_o(mem_req_addr),
        .mem_rsp_valid_i(rsp_drv | spur),
        .mem_rsp_data_i(rsp_drv ? rsp_data : 8'hFF),
        .fill_we_o(fill_we),
        .fill_addr_o(fill_addr),
        .fill_idx_o(fill_idx),
        .fill_data_o(fill_data),
        .crit_o(crit),
        .fill_done_o(fill_done),
        .busy_o(busy)
    );

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;
    logic [FW-1:0]     exp_q[$];
    logic [ADDR_W-1:0] req_q[$];

    int hs_count = 0;
    int bp_at    = -1;
    int bp_len   = 0;
    int bp_req   = 0;
    int bp_seen  = 0;
    int bp_left  = 0;
    logic              pend = 1'b0;
    logic [ADDR_W-1:0] pend_addr = '0;
    logic              prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;

    // Memory model and monitors; everything happens on the falling edge so DUT
    // outputs are stable and inputs are set up for the next rising edge.
    always @(negedge clk) begin
        logic [FW-1:0]     e;
        logic [FW-1:0]     got;
        logic [ADDR_W-1:0] ea;

        rsp_drv  = pend;
        rsp_data = pend_addr[7:0] ^ 8'hA5;
        pend     = 1'b0;

        if (prev_stall && !rst) begin
            tests++;
            if (!(mem_req_valid && mem_req_addr == prev_addr)) begin
                fails++;
                $display("FAIL req_hold valid=%b addr=%h expected valid=1 addr=%h",
                         mem_req_valid, mem_req_addr, prev_addr);
            end
        end

        if (bp_req != bp_seen) begin
            bp_seen = bp_req;
            bp_left = bp_len;
        end
        mem_ready  = !(hs_count == bp_at && bp_left > 0);
        prev_stall = 1'b0;
        if (mem_req_valid && !rst) begin
            if (mem_ready) begin
                pend      = 1'b1;
                pend_addr = mem_req_addr;
                hs_count++;
                tests++;
                if (req_q.size() == 0) begin
                    fails++;
                    $display("FAIL req_unexpected addr=%h expected none", mem_req_addr);
                end else begin
                    ea = req_q.pop_front();
                    if (mem_req_addr !== ea) begin
                        fails++;
                        $display("FAIL req_addr got=%h expected=%h", mem_req_addr, ea);
                    end
                end
            end else begin
                bp_left--;
                prev_stall = 1'b1;
                prev_addr  = mem_req_addr;
            end
        end

        if (fill_we) begin
            tests++;
            got = {fill_addr, fill_idx, fill_data, crit, fill_done};
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL fill_unexpected addr=%h idx=%0d data=%h expected no fill",
                         fill_addr, fill_idx, fill_data);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    fails++;
                    $display("FAIL fill got addr=%h idx=%0d data=%h crit=%b done=%b expected addr=%h idx=%0d data=%h crit=%b done=%b",
                             fill_addr, fill_idx, fill_data, crit, fill_done,
                             e[FW-1:FW-ADDR_W], e[12:10], e[9:2], e[1], e[0]);
                end
            end
        end else if (crit || fill_done) begin
            tests++;
            fails++;
            $display("FAIL pulse_without_we crit=%b done=%b expected 0", crit, fill_done);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_line(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] ra;
        logic [OFF_W-1:0]  st;
        logic [OFF_W-1:0]  idx;
        logic              c;
        logic              d;
        base = {a[ADDR_W-1:OFF_W], 3'b000};
        st   = a[OFF_W-1:0];
        for (int k = 0; k < LINE_BYTES; k++) begin
            idx = st + OFF_W'(k);
            ra  = base | {29'b0, idx};
            c   = (k == 0);
            d   = (k == LINE_BYTES - 1);
            req_q.push_back(ra);
            exp_q.push_back({base, idx, ra[7:0] ^ 8'hA5, c, d});
        end
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic issue_miss(input logic [ADDR_W-1:0] a, output int acc,
                              output int stalls, output int dones);
        bit ok;
        ok     = 1'b0;
        stalls = 0;
        dones  = 0;
        acc    = 0;
        push_line(a);
        miss_valid = 1'b1;
        miss_addr  = a;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (miss_ready) begin
                ok  = 1'b1;
                acc = cyc + 1;
            end else begin
                stalls++;
                if (fill_done) dones++;
                @(negedge clk);
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL miss_accept_timeout addr=%h expected acceptance", a);
        end
        @(negedge clk);
        miss_valid = 1'b0;
    endtask

    task automatic wait_done(input int acc, input int exp_lat, input string name);
        bit seen;
        int lat;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (fill_done) begin
                seen = 1'b1;
                lat  = cyc - acc;
            end else begin
                @(negedge clk);
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s done_timeout expected done after %0d cycles", name, exp_lat);
        end else if (lat != exp_lat) begin
            fails++;
            $display("FAIL %s latency got=%0d expected=%0d", name, lat, exp_lat);
        end
        @(negedge clk);
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int acc;
        int acc2;
        int st;
        int dn;
        int f;
        int ev;

        repeat (2) @(negedge clk);
        check_val("reset_outputs",
                  64'({mem_req_valid, mem_req_addr, fill_we, fill_addr, fill_idx,
                       fill_data, crit, fill_done, busy}), 64'd0);
        check_val("reset_miss_ready", 64'(miss_ready), 64'd1);
        rst = 1'b0;

        // stray response while idle
        spur = 1'b1;
        @(negedge clk);
        @(negedge clk);
        spur = 1'b0;
        check_val("idle_spur_state", 64'({busy, mem_req_valid, fill_we}), 64'd0);
        @(negedge clk);

        // aligned line, then critical-word-first wrap
        issue_miss(32'h100, acc, st, dn);
        wait_done(acc, 16, "aligned");
        issue_miss(32'h10B, acc, st, dn);
        wait_done(acc, 16, "wrap");

        // five cycles of request backpressure on the third beat
        bp_at  = hs_count + 2;
        bp_len = 5;
        bp_req++;
        @(negedge clk);
        issue_miss(32'h120, acc, st, dn);
        wait_done(acc, 21, "backpressure");

        // responses arriving while a request is still pending are ignored
        bp_at  = hs_count;
        bp_len = 3;
        bp_req++;
        @(negedge clk);
        issue_miss(32'h135, acc, st, dn);
        ev   = 0;
        spur = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (fill_we || fill_done) ev++;
        end
        spur = 1'b0;
        check_val("req_spur_no_fill", 64'(ev), 64'd0);
        check_val("req_spur_still_req", 64'({mem_req_valid, busy}), 64'b11);
        wait_done(acc, 19, "req_spur");

        // second miss presented while busy waits for the first line to finish
        issue_miss(32'h100, acc, st, dn);
        issue_miss(32'h200, acc2, st, dn);
        check_val("busy_miss_stalls", 64'(st), 64'd17);
        check_val("busy_miss_done_first", 64'(dn), 64'd1);
        check_val("busy_miss_accept_gap", 64'(acc2 - acc), 64'd18);
        wait_done(acc2, 16, "busy_second");

        // reset after three fills, then a stray response
        issue_miss(32'h300, acc, st, dn);
        f = 0;
        for (int i = 0; i < 100 && f < 3; i++) begin
            @(negedge clk);
            if (fill_we) f++;
        end
        check_val("mid_reset_fills_seen", 64'(f), 64'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_reset_outputs",
                  64'({mem_req_valid, mem_req_addr, fill_we, fill_addr, fill_idx,
                       fill_data, crit, fill_done, busy}), 64'd0);
        exp_q.delete();
        req_q.delete();
        spur = 1'b1;
        ev   = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            spur = 1'b0;
            if (fill_we || fill_done || busy || mem_req_valid) ev++;
        end
        check_val("post_reset_quiet", 64'(ev), 64'd0);

        issue_miss(32'h11D, acc, st, dn);
        wait_done(acc, 16, "after_reset");

        repeat (3) @(negedge clk);
        check_val("queues_drained", 64'(exp_q.size() + req_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
